// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants, requester IDs and address helper for the tap BRAM path
// Purpose: defaults for the tap store geometry and arbitration, plus the
//          requester identifier used between the arbiter and its priority core.
// Ports:   none (package).
package fir_pkg;

  localparam int DEPTH    = 11;
  localparam int ADDR_W   = 12;
  localparam int MAX_WAIT = 4;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_ENG  = 2'd1,
    REQ_CFG  = 2'd2
  } req_id_e;

  // Byte address to 32-bit word index; the two byte-lane bits are dropped.
  function automatic logic [ADDR_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/tap_arb_prio.sv
// rtl/tap_arb_prio.sv - engine-first priority with a starvation override for the cfg requester
// Purpose: picks the single requester served this cycle. The engine normally
//          wins; once cfg has lost MAX_WAIT_P consecutive cycles it is forced through.
// Ports:   clk_i, rst_i      clock and synchronous active-high reset
//          eng_req_i         engine request
//          cfg_req_i         configuration request
//          winner_o          requester granted this cycle (REQ_NONE while in reset)
module tap_arb_prio
  import fir_pkg::*;
#(
  parameter int MAX_WAIT_P = MAX_WAIT
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    eng_req_i,
  input  logic    cfg_req_i,
  output req_id_e winner_o
);

  localparam int               CNT_W    = $clog2(MAX_WAIT_P + 1);
  localparam logic [CNT_W-1:0] WAIT_TOP = CNT_W'(MAX_WAIT_P);

  logic [CNT_W-1:0] wait_q, wait_d;
  req_id_e          winner;

  always_comb begin
    winner = REQ_NONE;
    if (rst_i) begin
      winner = REQ_NONE;
    end else if (cfg_req_i && (wait_q == WAIT_TOP)) begin
      winner = REQ_CFG;
    end else if (eng_req_i) begin
      winner = REQ_ENG;
    end else if (cfg_req_i) begin
      winner = REQ_CFG;
    end
  end

  // Counts consecutive lost cycles of a pending cfg request only.
  always_comb begin
    wait_d = wait_q;
    if (!cfg_req_i || (winner == REQ_CFG)) begin
      wait_d = '0;
    end else if (wait_q != WAIT_TOP) begin
      wait_d = wait_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign winner_o = winner;

endmodule

// File: rtl/tap_bram_arbiter.sv
// rtl/tap_bram_arbiter.sv - single-port tap BRAM shared by the FIR engine and the config path
// Purpose: one BRAM access per cycle, 1-cycle read latency, bounds check,
//          run lock on config writes, EN held through every read data phase.
// Ports:   CLK, RST                         clock, synchronous active-high reset
//          eng_req/eng_addr                 engine read request (read-only)
//          eng_gnt/eng_rvalid/eng_rdata     engine accept and read response
//          cfg_req/cfg_we/cfg_addr/cfg_wdata config request
//          cfg_gnt/cfg_rvalid/cfg_rdata     config accept and read response
//          cfg_err                          pulse: config access dropped
//          run_lock                         FIR running, config writes suppressed
//          bram_WE/EN/Di/A, bram_Do         BRAM port
module tap_bram_arbiter #(
  parameter int DEPTH    = fir_pkg::DEPTH,
  parameter int ADDR_W   = fir_pkg::ADDR_W,
  parameter int MAX_WAIT = fir_pkg::MAX_WAIT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              eng_req,
  input  logic [ADDR_W-1:0] eng_addr,
  output logic              eng_gnt,
  output logic              eng_rvalid,
  output logic [31:0]       eng_rdata,
  input  logic              cfg_req,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic              cfg_gnt,
  output logic              cfg_rvalid,
  output logic [31:0]       cfg_rdata,
  output logic              cfg_err,
  input  logic              run_lock,
  output logic [3:0]        bram_WE,
  output logic              bram_EN,
  output logic [31:0]       bram_Di,
  output logic [ADDR_W-1:0] bram_A,
  input  logic [31:0]       bram_Do
);

  import fir_pkg::*;

  req_id_e           win;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write, req_oor, do_read, do_write;

  // Data-phase state for the access issued in the previous cycle.
  logic              eng_rv_q, eng_rv_d;
  logic              cfg_rv_q, cfg_rv_d;
  logic              rd_live_q, rd_live_d;  // previous read really touched the BRAM
  logic              err_q, err_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [31:0]       di_q, di_d;

  tap_arb_prio #(
    .MAX_WAIT_P(MAX_WAIT)
  ) u_prio (
    .clk_i    (CLK),
    .rst_i    (RST),
    .eng_req_i(eng_req),
    .cfg_req_i(cfg_req),
    .winner_o (win)
  );

  always_comb begin
    req_addr  = (win == REQ_CFG) ? cfg_addr : eng_addr;
    req_write = (win == REQ_CFG) && cfg_we;
    req_oor   = word_idx(req_addr) >= ADDR_W'(DEPTH);
    do_read   = (win != REQ_NONE) && !req_write && !req_oor;
    do_write  = req_write && !req_oor && !run_lock;
  end

  always_comb begin
    eng_rv_d  = (win == REQ_ENG);
    cfg_rv_d  = (win == REQ_CFG) && !cfg_we;
    rd_live_d = do_read;
    err_d     = (win == REQ_CFG) && (req_oor || (cfg_we && run_lock));
    // Address and write data only move on a real BRAM access, else they hold.
    a_d       = (do_read || do_write) ? req_addr : a_q;
    di_d      = do_write ? cfg_wdata : di_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      eng_rv_q  <= 1'b0;
      cfg_rv_q  <= 1'b0;
      rd_live_q <= 1'b0;
      err_q     <= 1'b0;
      a_q       <= '0;
      di_q      <= '0;
    end else begin
      eng_rv_q  <= eng_rv_d;
      cfg_rv_q  <= cfg_rv_d;
      rd_live_q <= rd_live_d;
      err_q     <= err_d;
      a_q       <= a_d;
      di_q      <= di_d;
    end
  end

  assign eng_gnt    = (win == REQ_ENG);
  assign cfg_gnt    = (win == REQ_CFG);
  // Responses are masked while RST is high so an in-flight read never reports.
  assign eng_rvalid = !RST && eng_rv_q;
  assign cfg_rvalid = !RST && cfg_rv_q;
  assign cfg_err    = !RST && err_q;
  // Only one read is ever in its data phase, so rd_live_q serves both sides.
  assign eng_rdata  = (eng_rvalid && rd_live_q) ? bram_Do : 32'h0;
  assign cfg_rdata  = (cfg_rvalid && rd_live_q) ? bram_Do : 32'h0;
  // BRAM Do is gated by EN, so EN stays high through the read data phase.
  assign bram_EN    = !RST && (do_read || do_write || rd_live_q);
  assign bram_WE    = do_write ? 4'hF : 4'h0;
  assign bram_A     = RST ? '0 : a_d;
  assign bram_Di    = RST ? 32'h0 : di_d;

endmodule

// File: tb/tb_tap_bram_arbiter.sv
// tb/tb_tap_bram_arbiter.sv - scoreboard bench for tap_bram_arbiter with a behavioural BRAM and tap model
module tb_tap_bram_arbiter;

  localparam int NWORD = 11;
  localparam int MAXW  = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        eng_req, cfg_req, cfg_we, run_lock;
  logic [11:0] eng_addr, cfg_addr;
  logic [31:0] cfg_wdata;
  logic        eng_gnt, eng_rvalid, cfg_gnt, cfg_rvalid, cfg_err, bram_EN;
  logic [31:0] eng_rdata, cfg_rdata, bram_Di, bram_Do;
  logic [3:0]  bram_WE;
  logic [11:0] bram_A;

  tap_bram_arbiter dut (
    .CLK(CLK), .RST(RST),
    .eng_req(eng_req), .eng_addr(eng_addr), .eng_gnt(eng_gnt),
    .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
    .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_gnt(cfg_gnt), .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
    .run_lock(run_lock),
    .bram_WE(bram_WE), .bram_EN(bram_EN), .bram_Di(bram_Di), .bram_A(bram_A),
    .bram_Do(bram_Do)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int en_cnt = 0;
  bit we_seen = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Behavioural BRAM: registered read, Do forced to 0 whenever EN is low.
  logic [31:0] bmem [0:15];
  logic [31:0] bram_r = 32'h0;
  always @(posedge CLK) begin
    if (bram_EN) begin
      if (bram_WE == 4'hF) bmem[bram_A[5:2]] <= bram_Di;
      bram_r <= bmem[bram_A[5:2]];
    end
  end
  assign bram_Do = bram_EN ? bram_r : 32'h0;

  always @(negedge CLK) begin
    if (bram_EN) en_cnt++;
    if (bram_WE != 4'h0) we_seen = 1'b1;
  end

  // Reference model: tap contents, cfg wait count, expected responses.
  typedef struct {
    int          due;
    logic        rv;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t        engq[$];
  exp_t        cfgq[$];
  logic [31:0] mmem [0:NWORD-1];
  int          cfg_wait = 0;

  always @(negedge CLK) begin : recorder
    int   idx;
    logic xe, xc;
    #1;
    if (RST) begin
      cfg_wait = 0;
    end else begin
      xe = eng_req && !(cfg_req && cfg_wait >= MAXW);
      xc = cfg_req && !xe;
      if (eng_req || cfg_req || eng_gnt || cfg_gnt)
        check("arb_gnt", 64'({eng_gnt, cfg_gnt}), 64'({xe, xc}));
      cfg_wait = (cfg_req && !xc) ? cfg_wait + 1 : 0;
      if (eng_gnt) begin
        idx = int'(eng_addr >> 2);
        engq.push_back('{cyc + 1, 1'b1, (idx < NWORD) ? mmem[idx] : 32'h0, 1'b0});
      end
      if (cfg_gnt) begin
        idx = int'(cfg_addr >> 2);
        if (cfg_we) begin
          if (idx < NWORD && !run_lock) mmem[idx] = cfg_wdata;
          cfgq.push_back('{cyc + 1, 1'b0, 32'h0, (idx >= NWORD) || run_lock});
        end else begin
          cfgq.push_back('{cyc + 1, 1'b1, (idx < NWORD) ? mmem[idx] : 32'h0, idx >= NWORD});
        end
      end
    end
  end

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RST) begin
      engq.delete();
      cfgq.delete();
      check("reset_data", {eng_rdata, cfg_rdata}, 64'h0);
      check("reset_ctrl", 64'({bram_Di, bram_A, bram_WE, bram_EN, eng_gnt, cfg_gnt,
                               eng_rvalid, cfg_rvalid, cfg_err}), 64'h0);
    end else begin
      if (engq.size() > 0 && engq[0].due == cyc) begin
        e = engq.pop_front();
        check("eng_resp", 64'({eng_rvalid, eng_rdata}), 64'({1'b1, e.data}));
      end else if (eng_rvalid) begin
        check("eng_unexpected_rvalid", 64'(eng_rvalid), 64'h0);
      end
      if (cfgq.size() > 0 && cfgq[0].due == cyc) begin
        e = cfgq.pop_front();
        check("cfg_resp", 64'({cfg_rvalid, cfg_err, cfg_rdata}), 64'({e.rv, e.err, e.data}));
      end else if (cfg_rvalid || cfg_err) begin
        check("cfg_unexpected_resp", 64'({cfg_rvalid, cfg_err}), 64'h0);
      end
    end
  end

  task automatic eng_rd(input logic [11:0] a, output int gcyc);
    bit got = 1'b0;
    gcyc = -1;
    @(posedge CLK); #1;
    eng_req = 1'b1; eng_addr = a;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (eng_gnt) begin got = 1'b1; gcyc = cyc; break; end
    end
    if (!got) check("eng_gnt_timeout", 64'h0, 64'h1);
  endtask

  task automatic cfg_op(input logic we, input logic [11:0] a, input logic [31:0] d,
                        output int waited);
    bit got = 1'b0;
    waited = 0;
    @(posedge CLK); #1;
    cfg_req = 1'b1; cfg_we = we; cfg_addr = a; cfg_wdata = d;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (cfg_gnt) begin got = 1'b1; break; end
      waited++;
    end
    if (!got) check("cfg_gnt_timeout", 64'h0, 64'h1);
    @(posedge CLK); #1;
    cfg_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, g, gfirst, glast, e0;
    RST = 1'b1; eng_req = 1'b0; cfg_req = 1'b0; cfg_we = 1'b0; run_lock = 1'b0;
    eng_addr = '0; cfg_addr = '0; cfg_wdata = '0;
    for (int i = 0; i < 16; i++) bmem[i] = $urandom;
    for (int i = 0; i < NWORD; i++) mmem[i] = bmem[i];
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("post_reset_data", {eng_rdata, cfg_rdata}, 64'h0);
    check("post_reset_ctrl", 64'({bram_Di, bram_A, bram_WE, bram_EN, eng_gnt, cfg_gnt,
                                  eng_rvalid, cfg_rvalid, cfg_err}), 64'h0);

    // Program taps 1..11, then read word 5 back.
    for (int i = 0; i < NWORD; i++) cfg_op(1'b1, 12'(i * 4), 32'(i + 1), w);
    cfg_op(1'b0, 12'h014, 32'h0, w);
    check("cfg_rd_no_wait", 64'(w), 64'd0);

    // Engine burst over all taps.
    repeat (3) @(posedge CLK);
    #1 e0 = en_cnt;
    gfirst = 0; glast = 0;
    for (int i = 0; i < NWORD; i++) begin
      eng_rd(12'(i * 4), g);
      if (i == 0) gfirst = g;
      glast = g;
    end
    @(posedge CLK); #1 eng_req = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("burst_gnt_span", 64'(glast - gfirst), 64'd10);
    check("burst_en_cycles", 64'(en_cnt - e0), 64'd12);

    // Starvation: cfg must win after exactly MAXW lost cycles.
    fork
      begin
        for (int i = 0; i < 8; i++) eng_rd(12'(i * 4), g);
      end
      begin
        @(posedge CLK);
        cfg_op(1'b0, 12'h01C, 32'h0, w);
      end
    join
    @(posedge CLK); #1 eng_req = 1'b0;
    check("starve_wait", 64'(w), 64'(MAXW));

    // Locked write is dropped with an error pulse.
    @(posedge CLK); #1;
    run_lock = 1'b1; we_seen = 1'b0;
    cfg_op(1'b1, 12'h008, 32'hDEAD_BEEF, w);
    repeat (2) @(posedge CLK);
    #1;
    check("locked_we", 64'(we_seen), 64'h0);
    run_lock = 1'b0;
    cfg_op(1'b0, 12'h008, 32'h0, w);

    // Out-of-range reads from both sides never enable the BRAM.
    repeat (2) @(posedge CLK);
    #1 e0 = en_cnt;
    fork
      cfg_op(1'b0, 12'h02C, 32'h0, w);
      begin
        eng_rd(12'h030, g);
        @(posedge CLK); #1 eng_req = 1'b0;
      end
    join
    repeat (2) @(posedge CLK);
    #1;
    check("oor_en_cycles", 64'(en_cnt - e0), 64'h0);

    // Reset in the data phase of an engine read, with cfg already starving.
    fork
      cfg_op(1'b0, 12'h00C, 32'h0, w);
      begin
        eng_rd(12'h004, g);
        eng_rd(12'h008, g);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        for (int i = 0; i < 6; i++) eng_rd(12'h010, g);
        @(posedge CLK); #1 eng_req = 1'b0;
      end
    join

    // Randomised traffic from both requesters with a toggling run lock.
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          eng_rd(12'($urandom_range(0, 63)), g);
          if ($urandom_range(0, 2) == 0) begin
            @(posedge CLK); #1 eng_req = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge CLK);
          end
        end
        @(posedge CLK); #1 eng_req = 1'b0;
      end
      begin
        for (int i = 0; i < 40; i++)
          cfg_op(1'($urandom_range(0, 1)), 12'($urandom_range(0, 63)), $urandom, w);
      end
      begin
        for (int i = 0; i < 350; i++) begin
          @(posedge CLK); #1 run_lock = ($urandom_range(0, 3) == 0);
        end
        run_lock = 1'b0;
      end
    join

    // Read back every tap against the model after the random phase.
    for (int i = 0; i < NWORD; i++) cfg_op(1'b0, 12'(i * 4), 32'h0, w);
    repeat (4) @(posedge CLK);
    #1;
    check("eng_queue_drained", 64'(engq.size()), 64'h0);
    check("cfg_queue_drained", 64'(cfgq.size()), 64'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
